// File: rtl/alu_sequencer.sv
// alu_sequencer: drives an external ALU through one operation.
// The sequencer reads operand A (and B for binary ops) from the shared bus,
// holds the operands through EXEC, asks the ALU to drive its result during
// WRITE, and captures the ALU flags at the WRITE edge.
//
// Request handshake: in_start is a level request that is only looked at while
// the block is in IDLE (out_busy=0). A request seen at a rising edge in IDLE is
// accepted at that edge together with in_op; requests made while out_busy=1,
// including the WRITE cycle, are dropped without queuing. Completion is the
// single-cycle out_done pulse, after which out_flags holds the new flags.
module alu_sequencer (
    input  logic       clk,
    input  logic       in_reset_n,
    input  logic       in_start,
    input  logic [2:0] in_op,
    input  logic [7:0] in_bus,
    input  logic [3:0] in_alu_flags,
    output logic [7:0] out_A,
    output logic [7:0] out_B,
    output logic [2:0] out_op,
    output logic       out_alu_enable_out,
    output logic       out_bus_rd,
    output logic       out_operand_sel,
    output logic       out_busy,
    output logic       out_done,
    output logic [3:0] out_flags,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;
    logic   op_is_unary;

    // not, shr and shl take only operand A
    assign op_is_unary = (out_op == 3'b100) || (out_op == 3'b110) || (out_op == 3'b111);

    assign dbg_state = state;

    // State register; reset wins over any transition
    always_ff @(posedge clk) begin
        if (!in_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_next         = state;
        out_alu_enable_out = 1'b0;
        out_bus_rd         = 1'b0;
        out_operand_sel    = 1'b0;
        out_busy           = 1'b1;
        out_done           = 1'b0;
        case (state)
            S_IDLE: begin
                out_busy = 1'b0;
                if (in_start) begin
                    state_next = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                out_bus_rd = 1'b1;
                state_next = op_is_unary ? S_EXEC : S_LOAD_B;
            end
            S_LOAD_B: begin
                out_bus_rd      = 1'b1;
                out_operand_sel = 1'b1;
                state_next      = S_EXEC;
            end
            S_EXEC: begin
                // operands and opcode stay put while the ALU registers its result
                state_next = S_WRITE;
            end
            S_WRITE: begin
                out_alu_enable_out = 1'b1;
                out_done           = 1'b1;
                state_next         = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand, opcode and flag registers; all hold outside their load state
    always_ff @(posedge clk) begin
        if (!in_reset_n) begin
            out_A     <= 8'h00;
            out_B     <= 8'h00;
            out_op    <= 3'b000;
            out_flags <= 4'b0000;
        end else begin
            case (state)
                S_IDLE:   if (in_start) out_op <= in_op;
                S_LOAD_A: out_A     <= in_bus;
                S_LOAD_B: out_B     <= in_bus;
                S_WRITE:  out_flags <= in_alu_flags;
                default:  ;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port in_reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port in_start, input, 1 bit: request one ALU operation; sampled only in IDLE.
REQ-004 SHALL have port in_op, input, 3 bits: opcode, captured with an accepted in_start.
REQ-005 SHALL have port in_bus, input, 8 bits: shared data bus carrying operands.
REQ-006 SHALL have port in_alu_flags, input, 4 bits: ALU flags {C,N,O,Z}.
REQ-007 SHALL have port out_A, output, 8 bits: operand A to the ALU.
REQ-008 SHALL have port out_B, output, 8 bits: operand B to the ALU.
REQ-009 SHALL have port out_op, output, 3 bits: opcode to the ALU.
REQ-010 SHALL have port out_alu_enable_out, output, 1 bit: drives the ALU in_enable_out; high puts the result on the bus.
REQ-011 SHALL have port out_bus_rd, output, 1 bit: high while an operand is being read from in_bus.
REQ-012 SHALL have port out_operand_sel, output, 1 bit: 0 = A being read, 1 = B being read; meaningful only while out_bus_rd is high.
REQ-013 SHALL have port out_busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port out_done, output, 1 bit: one-cycle pulse in the WRITE cycle.
REQ-015 SHALL have port out_flags, output, 4 bits: registered flags {C,N,O,Z} of the last completed operation.

Function
REQ-016 SHALL implement five states: IDLE, LOAD_A, LOAD_B, EXEC, WRITE.
REQ-017 IDLE with in_start=1: SHALL capture in_op into out_op and go to LOAD_A; with in_start=0 SHALL remain in IDLE.
REQ-018 LOAD_A: out_bus_rd=1, out_operand_sel=0; at the clock edge SHALL latch in_bus into out_A.
REQ-019 From LOAD_A, SHALL go to EXEC if out_op is unary (3'b100 not, 3'b110 shr, 3'b111 shl), otherwise to LOAD_B.
REQ-020 LOAD_B: out_bus_rd=1, out_operand_sel=1; SHALL latch in_bus into out_B and go to EXEC.
REQ-021 For unary ops, out_B SHALL keep its previous value (not cleared).
REQ-022 EXEC: all outputs to the ALU held stable for this cycle, because the ALU registers its result at the edge ending EXEC; next state WRITE.
REQ-023 WRITE: out_alu_enable_out=1 and out_done=1; at the edge SHALL load in_alu_flags into out_flags, then go to IDLE.
REQ-024 out_alu_enable_out, out_done and out_bus_rd SHALL be 0 in every state other than those stated above.
REQ-025 out_A, out_B and out_op SHALL hold their values from WRITE until the next accepted start, so the ALU's combinational flags remain stable.
REQ-026 Latency from the in_start-accept edge to out_done high: 4 cycles for binary ops, 3 cycles for unary ops.
REQ-027 in_start while out_busy=1 SHALL be ignored, with no queuing.
REQ-028 in_start asserted in the WRITE cycle SHALL be ignored; a new start is accepted no earlier than the first IDLE cycle.
REQ-029 out_flags SHALL change only at the WRITE edge or on reset.

Reset
REQ-030 in_reset_n=0 at a clock edge SHALL force: state IDLE, out_A=0, out_B=0, out_op=0, out_flags=0, out_done=0, out_alu_enable_out=0, out_bus_rd=0.
REQ-031 Reset SHALL take priority over in_start and over any state transition.
REQ-032 Reset mid-operation SHALL abandon the operation: no out_done pulse, flags cleared to 0 (not updated from the ALU).
REQ-033 While in_reset_n=0, the block SHALL accept no in_start.

Verification
REQ-034 Add: op=000, A=0x7F, B=0x01 -> ALU bus 0x80 during WRITE, out_done in cycle 4, out_flags=4'b0110.
REQ-035 Sub: op=001, A=0x05, B=0x05 -> result 0x00, out_flags=4'b0001.
REQ-036 Unary shr: op=110, A=0x03 -> no LOAD_B cycle, result 0x01, out_done in cycle 3, out_flags=4'b1000.
REQ-037 Cmp: op=101, A=0x10, B=0x10 -> out_flags Z=1 (4'b0001); out_A, out_B and out_op still held one cycle after WRITE.
REQ-038 in_start pulsed during LOAD_B and during WRITE -> ignored; exactly one out_done.
REQ-039 in_reset_n=0 during LOAD_B after a prior op left out_flags=4'b0110 -> IDLE next cycle, out_flags=0, no out_done.
